// File: rtl/machine_mode_types_pkg.sv
// Machine-mode trap types: cause codes, sequencer states and the mcause layout.
package machine_mode_types_pkg;

  typedef enum logic [3:0] {
    EXC_MAL_INSN   = 4'd0,
    EXC_FAULT_INSN = 4'd1,
    EXC_ILLEGAL    = 4'd2,
    EXC_BREAK      = 4'd3,
    EXC_MAL_L      = 4'd4,
    EXC_FAULT_L    = 4'd5,
    EXC_MAL_S      = 4'd6,
    EXC_FAULT_S    = 4'd7,
    EXC_ECALL_M    = 4'd11
  } ex_code_t;

  typedef enum logic [3:0] {
    INT_SOFT  = 4'd3,
    INT_TIMER = 4'd7,
    INT_EXT   = 4'd11
  } int_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_CLR,
    ST_REDIRECT
  } trap_state_t;

  localparam int MCAUSE_INT_BIT = 31;

  function automatic logic [31:0] mk_mcause(input logic is_int, input logic [3:0] code);
    logic [31:0] v;
    v = '0;
    v[MCAUSE_INT_BIT] = is_int;
    v[3:0] = code;
    return v;
  endfunction

endpackage

// File: rtl/prv_cause_encoder.sv
// Fixed-priority trap cause encoder; any exception outranks any interrupt.
module prv_cause_encoder
  import machine_mode_types_pkg::*;
(
  input  logic [8:0] exc_vec,
  input  logic [2:0] irq_vec,   // {ext,timer,soft}, already masked by mie and mstatus.MIE
  output logic       valid,
  output logic       intr,
  output logic [3:0] code
);

  always_comb begin
    valid = 1'b1;
    intr  = 1'b0;
    code  = EXC_MAL_INSN;
    // exc_vec bit order is fetch-side first, so scan LSB upward except env_m sits before loads
    if      (exc_vec[0]) code = EXC_FAULT_INSN;
    else if (exc_vec[1]) code = EXC_MAL_INSN;
    else if (exc_vec[2]) code = EXC_ILLEGAL;
    else if (exc_vec[3]) code = EXC_BREAK;
    else if (exc_vec[4]) code = EXC_ECALL_M;
    else if (exc_vec[5]) code = EXC_MAL_L;
    else if (exc_vec[6]) code = EXC_FAULT_L;
    else if (exc_vec[7]) code = EXC_MAL_S;
    else if (exc_vec[8]) code = EXC_FAULT_S;
    else begin
      intr = 1'b1;
      if      (irq_vec[2]) code = INT_EXT;
      else if (irq_vec[0]) code = INT_SOFT;
      else if (irq_vec[1]) code = INT_TIMER;
      else begin
        valid = 1'b0;
        intr  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap sequencer: latch cause, wait for flush, redirect for one cycle.
// Optional PRV_VECTORED_INTR_EN: interrupts jump to base + 4*code when mtvec mode is vectored.
module prv_trap_ctrl
  import machine_mode_types_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [8:0]  exc_vec,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic [2:0]  irq_en,
  input  logic        gie,
  input  logic [31:0] epc,
  input  logic        ret,
  input  logic        pipe_clear,
  input  logic [31:0] mtvec,
  input  logic        mtvec_valid,
  input  logic [31:0] mepc_q,
  output logic [31:0] npc,
  output logic        insert_pc,
  output logic        intr,
  output logic [31:0] mcause_wdata,
  output logic [31:0] mepc_wdata,
  output logic        trap_wen,
  output logic        ret_wen
);

  trap_state_t state, state_nx;
  logic [2:0]  irq_vec;
  logic        ev_valid, ev_intr;
  logic [3:0]  ev_code;
  logic        cap_trap, cap_ret;
  logic        lat_intr, lat_ret;
  logic [31:0] base, trap_pc;

  assign irq_vec = {ext_int, timer_int, soft_int} & irq_en & {3{gie}};

  prv_cause_encoder u_enc (
    .exc_vec (exc_vec),
    .irq_vec (irq_vec),
    .valid   (ev_valid),
    .intr    (ev_intr),
    .code    (ev_code)
  );

  always_comb begin
    state_nx = state;
    cap_trap = 1'b0;
    cap_ret  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev_valid) begin
          cap_trap = 1'b1;
          state_nx = pipe_clear ? ST_REDIRECT : ST_WAIT_CLR;
        end else if (ret) begin
          cap_ret  = 1'b1;
          state_nx = ST_REDIRECT;
        end
      end
      ST_WAIT_CLR: if (pipe_clear) state_nx = ST_REDIRECT;
      ST_REDIRECT: state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      lat_intr     <= 1'b0;
      lat_ret      <= 1'b0;
      mcause_wdata <= '0;
      mepc_wdata   <= '0;
    end else begin
      state <= state_nx;
      if (cap_trap) begin
        lat_intr     <= ev_intr;
        lat_ret      <= 1'b0;
        mcause_wdata <= mk_mcause(ev_intr, ev_code);
        mepc_wdata   <= epc;
      end else if (cap_ret) begin
        lat_intr <= 1'b0;
        lat_ret  <= 1'b1;
      end
    end
  end

  // masking keeps all of mtvec referenced; the mode bits only matter when vectoring
  assign base = mtvec_valid ? (mtvec & ~32'h3) : MTVEC_RESET;

`ifdef PRV_VECTORED_INTR_EN
  assign trap_pc = (lat_intr && mtvec_valid && mtvec[1:0] == 2'b01)
                 ? base + {26'b0, mcause_wdata[3:0], 2'b00} : base;
`else
  assign trap_pc = base;
`endif

  assign insert_pc = (state == ST_REDIRECT);
  assign npc       = insert_pc ? (lat_ret ? mepc_q : trap_pc) : '0;
  assign intr      = lat_intr;
  assign trap_wen  = insert_pc & ~lat_ret;
  assign ret_wen   = insert_pc & lat_ret;

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Scoreboard bench for prv_trap_ctrl: stimulus queues expected redirects, monitor checks them.
module tb_prv_trap_ctrl;

  logic        CLK, RST;
  logic [8:0]  exc_vec;
  logic        timer_int, soft_int, ext_int, gie, ret, pipe_clear, mtvec_valid;
  logic [2:0]  irq_en;
  logic [31:0] epc, mtvec, mepc_q;
  logic [31:0] npc, mcause_wdata, mepc_wdata;
  logic        insert_pc, intr, trap_wen, ret_wen;

  prv_trap_ctrl dut (
    .CLK(CLK), .RST(RST), .exc_vec(exc_vec), .timer_int(timer_int), .soft_int(soft_int),
    .ext_int(ext_int), .irq_en(irq_en), .gie(gie), .epc(epc), .ret(ret),
    .pipe_clear(pipe_clear), .mtvec(mtvec), .mtvec_valid(mtvec_valid), .mepc_q(mepc_q),
    .npc(npc), .insert_pc(insert_pc), .intr(intr), .mcause_wdata(mcause_wdata),
    .mepc_wdata(mepc_wdata), .trap_wen(trap_wen), .ret_wen(ret_wen)
  );

  typedef struct {
    int          cyc;
    logic [31:0] npc;
    logic        intr;
    logic        chk_data;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic        trap;
    logic        rtn;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0, n_fail = 0, cyc = 0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every redirect must match the oldest queued expectation
  always @(negedge CLK) begin
    if (!RST) begin
      if (insert_pc) begin
        if (q.size() == 0) begin
          chk("unexpected_insert_pc", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("redirect_cycle", cyc, e.cyc);
          chk("npc", npc, e.npc);
          chk("intr", {31'b0, intr}, {31'b0, e.intr});
          chk("trap_wen", {31'b0, trap_wen}, {31'b0, e.trap});
          chk("ret_wen", {31'b0, ret_wen}, {31'b0, e.rtn});
          if (e.chk_data) begin
            chk("mcause_wdata", mcause_wdata, e.mcause);
            chk("mepc_wdata", mepc_wdata, e.mepc);
          end
        end
      end else if (trap_wen || ret_wen) begin
        chk("strobe_without_insert", {30'b0, trap_wen, ret_wen}, 32'd0);
      end
    end
  end

  task automatic push(input int c, input logic [31:0] n, input logic i, input logic d,
                      input logic [31:0] mc, input logic [31:0] me, input logic t, input logic r);
    exp_t x;
    x.cyc = c; x.npc = n; x.intr = i; x.chk_data = d;
    x.mcause = mc; x.mepc = me; x.trap = t; x.rtn = r;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // one cycle of event stimulus, then events drop back to zero
  task automatic send(input logic [8:0] exc, input logic [2:0] ints, input logic r,
                      input logic clr, input logic [31:0] pc);
    exc_vec = exc;
    {ext_int, timer_int, soft_int} = ints;
    ret = r; pipe_clear = clr; epc = pc;
    tick();
    exc_vec = '0; {ext_int, timer_int, soft_int} = 3'b0; ret = 0; pipe_clear = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_npc"}, npc, 32'h0);
    chk({tag, "_insert_pc"}, {31'b0, insert_pc}, 32'h0);
    chk({tag, "_intr"}, {31'b0, intr}, 32'h0);
    chk({tag, "_trap_wen"}, {31'b0, trap_wen}, 32'h0);
    chk({tag, "_ret_wen"}, {31'b0, ret_wen}, 32'h0);
    chk({tag, "_mcause"}, mcause_wdata, 32'h0);
    chk({tag, "_mepc"}, mepc_wdata, 32'h0);
  endtask

  logic [31:0] vec_npc;
  int c0, budget;

  initial begin
    RST = 1; exc_vec = '0; timer_int = 0; soft_int = 0; ext_int = 0; irq_en = 3'b0;
    gie = 0; epc = '0; ret = 0; pipe_clear = 0; mtvec = 32'h200; mtvec_valid = 1;
    mepc_q = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("reset");
    tick();
    RST = 0;
    tick();

    // illegal instruction, flush already done
    push(cyc + 1, 32'h200, 0, 1, 32'h2, 32'h80, 1, 0);
    send(9'b0_0000_0100, 3'b000, 0, 1, 32'h80);
    tick(); tick();

    // fault_l + mal_s + timer: fault_l wins
    gie = 1; irq_en = 3'b111;
    push(cyc + 1, 32'h200, 0, 1, 32'h5, 32'h90, 1, 0);
    send(9'b0_1100_0000, 3'b010, 0, 1, 32'h90);
    gie = 0;
    tick(); tick();

    // soft + timer interrupt, vectored-mode mtvec
    gie = 1; irq_en = 3'b111; mtvec = 32'h201;
`ifdef PRV_VECTORED_INTR_EN
    vec_npc = 32'h20C;
`else
    vec_npc = 32'h200;
`endif
    push(cyc + 1, vec_npc, 1, 1, 32'h8000_0003, 32'h94, 1, 0);
    send(9'b0, 3'b011, 0, 1, 32'h94);
    gie = 0;
    tick();
    mtvec = 32'h200;
    tick();

    // ecall waiting 3 cycles for flush; ext_int and new epc meanwhile ignored
    c0 = cyc;
    push(c0 + 4, 32'h200, 0, 1, 32'd11, 32'hA0, 1, 0);
    exc_vec = 9'b0_0001_0000; epc = 32'hA0; pipe_clear = 0;
    tick();
    exc_vec = '0; ext_int = 1; gie = 1; irq_en = 3'b111; epc = 32'hB0;
    tick(); tick();
    ext_int = 0; gie = 0; pipe_clear = 1;
    tick();
    pipe_clear = 0;
    tick(); tick();

    // mret
    mepc_q = 32'h1234;
    push(cyc + 1, 32'h1234, 0, 0, 32'h0, 32'h0, 0, 1);
    send(9'b0, 3'b000, 1, 0, 32'hC0);
    tick(); tick();

    // mret + breakpoint: breakpoint taken, ret dropped
    push(cyc + 1, 32'h200, 0, 1, 32'h3, 32'hC4, 1, 0);
    send(9'b0_0000_1000, 3'b000, 1, 1, 32'hC4);
    tick(); tick();

    // back-to-back: inputs held through REDIRECT are ignored, next trap the cycle after
    c0 = cyc;
    push(c0 + 1, 32'h200, 0, 1, 32'h2, 32'hD0, 1, 0);
    push(c0 + 3, 32'h200, 0, 1, 32'h7, 32'hD8, 1, 0);
    exc_vec = 9'b0_0000_0100; pipe_clear = 1; epc = 32'hD0;
    tick();
    epc = 32'hD4;
    tick();
    exc_vec = 9'b1_0000_0000; epc = 32'hD8;
    tick();
    exc_vec = '0; pipe_clear = 0;
    tick(); tick();

    // priority corners and mtvec_valid=0 fallback
    mtvec_valid = 0;
    push(cyc + 1, 32'h100, 0, 1, 32'h1, 32'hE0, 1, 0);
    send(9'b0_0000_0011, 3'b000, 0, 1, 32'hE0);
    tick(); tick();
    push(cyc + 1, 32'h100, 0, 1, 32'h0, 32'hE4, 1, 0);
    send(9'b0_0000_0010, 3'b000, 0, 1, 32'hE4);
    tick(); tick();
    mtvec_valid = 1;
    gie = 1; irq_en = 3'b111;
    push(cyc + 1, 32'h200, 1, 1, 32'h8000_000B, 32'hE8, 1, 0);
    send(9'b0, 3'b101, 0, 1, 32'hE8);
    gie = 0;
    tick(); tick();
    gie = 1; irq_en = 3'b011;
    push(cyc + 1, 32'h200, 1, 1, 32'h8000_0007, 32'hEC, 1, 0);
    send(9'b0, 3'b110, 0, 1, 32'hEC);
    gie = 0;
    tick(); tick();
    // gie low: pending interrupt must not trap
    irq_en = 3'b111;
    send(9'b0, 3'b111, 0, 1, 32'hF0);
    tick(); tick();

    // reset while waiting for flush: no redirect afterwards
    send(9'b0_0000_0001, 3'b000, 0, 0, 32'hF4);
    RST = 1;
    tick();
    RST = 0; pipe_clear = 1;
    tick(); tick();
    pipe_clear = 0;
    @(negedge CLK);
    chk_reset_outputs("post_rst");
    tick();

    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      tick();
      budget++;
    end
    chk("queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
